int_ctrl: RTL and testbench

- Interrupt controller directly upstream of the multi-cycle CPU core.
- Collects NUM_IRQ external interrupt lines, edge-detects them into a pending register, applies a mask and fixed priority, and drives the CPU's int_signal / int_cause.
- Holds the request until the core acknowledges entry to the handler, then blocks further requests until software writes EOI.
- Software accesses it as memory-mapped registers on the CPU bus (addr_out/data_out/mem_w), returning read data and a ready strobe toward the CPU's data_in and mio_ready.

---
 rtl/cpu_defs.sv | 24 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/int_ctrl.sv | 168 ++++++++++++++++
 tb/tb_int_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU/interrupt definitions: register offsets, controller FSM encoding, cause layout.
package cpu_defs;

  localparam logic [3:0] INT_PENDING = 4'h0;
  localparam logic [3:0] INT_MASK    = 4'h4;
  localparam logic [3:0] INT_CAUSE   = 4'h8;
  localparam logic [3:0] INT_EOI     = 4'hC;

  localparam int CAUSE_VLD_BIT = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } int_state_e;

  function automatic logic [31:0] make_cause(input logic [4:0] id);
    logic [31:0] c;
    c = 32'(id);
    c[CAUSE_VLD_BIT] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; purely combinational, no backpressure.
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  output logic         vld_o,
  output logic [4:0]   id_o
);

  always_comb begin
    vld_o = 1'b0;
    id_o  = 5'd0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        vld_o = 1'b1;
        id_o  = 5'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detect -> pending -> mask/priority -> registered int_signal; 1-cycle bus ready.
// INT_SYNC_EN adds a 2-flop input synchronizer (edge to int_signal 4 cycles instead of 2).
module int_ctrl
  import cpu_defs::*;
#(
  parameter int          NUM_IRQ   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        addr_in,
  input  logic [31:0]        wdata,
  input  logic               mem_w,
  input  logic               mem_req,
  output logic [31:0]        rdata,
  output logic               sel,
  output logic               ready,
  output logic               int_signal,
  output logic [31:0]        int_cause,
  input  logic               int_ack
);

  logic [NUM_IRQ-1:0] src, prev_q, rise, pending_q, pending_d, mask_q, mask_d, win_oh;
  int_state_e         state_q, state_d;
  logic [4:0]         win_id_q, win_id_d, svc_id_q, svc_id_d, req_id;
  logic               int_signal_q, int_signal_d, ready_q, req_vld, win_hold, ack_clr;
  logic [31:0]        int_cause_q, int_cause_d, rdata_q, rdata_d;
  logic [3:0]         offset;
  logic               wr, rd, wr_pend, wr_mask, wr_eoi;
  logic               unused_ok;

`ifdef INT_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign src = sync2_q;
`else
  assign src = irq_in;
`endif

  assign rise = src & ~prev_q;

  assign sel     = (addr_in[31:4] == BASE_ADDR[31:4]) && mem_req;
  assign offset  = {addr_in[3:2], 2'b00};
  assign wr      = sel && mem_w;
  assign rd      = sel && !mem_w;
  assign wr_pend = wr && (offset == INT_PENDING);
  assign wr_mask = wr && (offset == INT_MASK);
  assign wr_eoi  = wr && (offset == INT_EOI);

  assign unused_ok = ^{addr_in[1:0], wdata[31:NUM_IRQ]};

  irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req_i (pending_q & mask_q),
    .vld_o (req_vld),
    .id_o  (req_id)
  );

  assign win_oh   = NUM_IRQ'(1) << win_id_q;
  assign win_hold = |(pending_q & mask_q & win_oh);

  always_comb begin
    state_d      = state_q;
    win_id_d     = win_id_q;
    svc_id_d     = svc_id_q;
    int_signal_d = int_signal_q;
    int_cause_d  = int_cause_q;
    ack_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_vld) begin
          state_d      = ASSERT;
          win_id_d     = req_id;
          int_signal_d = 1'b1;
          int_cause_d  = make_cause(req_id);
        end
      end
      ASSERT: begin
        if (int_ack) begin
          ack_clr      = 1'b1;
          svc_id_d     = win_id_q;
          int_signal_d = 1'b0;
          int_cause_d  = '0;
          state_d      = SERVICE;
        end else if (!win_hold) begin
          // Request withdrawn by software before the core took it.
          int_signal_d = 1'b0;
          int_cause_d  = '0;
          state_d      = IDLE;
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          svc_id_d = 5'd0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        int_signal_d = 1'b0;
        int_cause_d  = '0;
      end
    endcase
  end

  // New edges are OR-ed in last so a same-cycle set beats W1C and ack clears.
  always_comb begin
    pending_d = pending_q;
    if (wr_pend) pending_d = pending_d & ~wdata[NUM_IRQ-1:0];
    if (ack_clr) pending_d = pending_d & ~win_oh;
    pending_d = pending_d | rise;
    mask_d    = wr_mask ? wdata[NUM_IRQ-1:0] : mask_q;
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (offset)
        INT_PENDING: rdata_d = 32'(pending_q);
        INT_MASK:    rdata_d = 32'(mask_q);
        INT_CAUSE:   rdata_d = {state_q == SERVICE, 26'b0, svc_id_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      state_q      <= IDLE;
      win_id_q     <= '0;
      svc_id_q     <= '0;
      int_signal_q <= 1'b0;
      int_cause_q  <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
    end else begin
      prev_q       <= src;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      state_q      <= state_d;
      win_id_q     <= win_id_d;
      svc_id_q     <= svc_id_d;
      int_signal_q <= int_signal_d;
      int_cause_q  <= int_cause_d;
      rdata_q      <= rdata_d;
      ready_q      <= sel;
    end
  end

  assign rdata      = rdata_q;
  assign ready      = ready_q;
  assign int_signal = int_signal_q;
  assign int_cause  = int_cause_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: bus read data and interrupt causes are queued and checked by monitors.
module tb_int_ctrl;

`ifdef INT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  irq_in = '0;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata = '0;
  logic        mem_w = 1'b0;
  logic        mem_req = 1'b0;
  logic        int_ack = 1'b0;
  logic [31:0] rdata, int_cause;
  logic        sel, ready, int_signal;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_q[$];
  logic [31:0] cause_q[$];
  logic        bus_act = 1'b0;
  logic        exp_rdy = 1'b0;
  logic        int_prev = 1'b0;
  logic        mon_en = 1'b0;

  int_ctrl #(.NUM_IRQ(8), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .addr_in    (addr_in),
    .wdata      (wdata),
    .mem_w      (mem_w),
    .mem_req    (mem_req),
    .rdata      (rdata),
    .sel        (sel),
    .ready      (ready),
    .int_signal (int_signal),
    .int_cause  (int_cause),
    .int_ack    (int_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle bus access; in-range accesses queue their expected read data (0 for writes).
  task automatic bus(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic in_range);
    addr_in = addr;
    mem_w   = we;
    wdata   = wd;
    mem_req = 1'b1;
    bus_act = in_range;
    if (in_range) rd_q.push_back(we ? 32'h0 : exp_rd);
    #1;
    chk("sel", {31'b0, sel}, {31'b0, in_range});
    tick();
    mem_req = 1'b0;
    mem_w   = 1'b0;
    bus_act = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp);
    bus(BASE | 32'(off), 1'b0, 32'h0, exp, 1'b1);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    bus(BASE | 32'(off), 1'b1, d, 32'h0, 1'b1);
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  always @(posedge clk) exp_rdy <= bus_act;

  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_en) begin
      if (ready || exp_rdy) begin
        checks++;
        if (ready !== exp_rdy) begin
          errors++;
          $display("FAIL ready actual=%0b expected=%0b", ready, exp_rdy);
        end else if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          chk("rdata", rdata, e);
        end
      end
      if (int_signal && !int_prev) begin
        checks++;
        if (cause_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_int actual_cause=%h expected=none", int_cause);
        end else begin
          e = cause_q.pop_front();
          chk("int_cause_mon", int_cause, e);
        end
      end
      int_prev = int_signal;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tickn(2);
    reset = 1'b1;
    chk("rst_int_signal", {31'b0, int_signal}, 32'h0);
    chk("rst_int_cause", int_cause, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    mon_en = 1'b1;
    rd(4'h4, 32'h0);
    rd(4'h0, 32'h0);

    // Single source, fixed latency
    wr(4'h4, 32'hFF);
    rd(4'h4, 32'hFF);
    bus(BASE | 32'h7, 1'b0, 32'h0, 32'hFF, 1'b1);
    bus(32'hFFFF_FE04, 1'b0, 32'h0, 32'h0, 1'b0);
    irq_in[3] = 1'b1;
    cause_q.push_back(32'h8000_0003);
    tickn(LAT - 1);
    chk("lat_before", {31'b0, int_signal}, 32'h0);
    tick();
    chk("lat_at", {31'b0, int_signal}, 32'h1);
    chk("cause3", int_cause, 32'h8000_0003);
    irq_in[3] = 1'b0;
    rd(4'h0, 32'h08);
    ack();
    chk("ack_drop", {31'b0, int_signal}, 32'h0);
    chk("ack_cause0", int_cause, 32'h0);
    rd(4'h8, 32'h8000_0003);
    rd(4'h0, 32'h0);
    wr(4'hC, 32'h0);
    rd(4'hC, 32'h0);

    // Two sources together: lowest index first, other after EOI
    irq_in = 8'h24;
    cause_q.push_back(32'h8000_0002);
    cause_q.push_back(32'h8000_0005);
    tickn(LAT);
    chk("prio_id2", int_cause, 32'h8000_0002);
    irq_in = 8'h00;
    ack();
    tick();
    chk("svc_block", {31'b0, int_signal}, 32'h0);
    wr(4'hC, 32'h0);
    chk("eoi_edge", {31'b0, int_signal}, 32'h0);
    tick();
    chk("next_id5", int_cause, 32'h8000_0005);
    ack();
    wr(4'hC, 32'h0);

    // Masked source stays pending until unmasked
    wr(4'h4, 32'h00);
    irq_in[1] = 1'b1;
    tickn(LAT + 2);
    chk("masked_quiet", {31'b0, int_signal}, 32'h0);
    irq_in[1] = 1'b0;
    rd(4'h0, 32'h02);
    cause_q.push_back(32'h8000_0001);
    wr(4'h4, 32'h02);
    chk("unmask_edge", {31'b0, int_signal}, 32'h0);
    tick();
    chk("unmask_int", int_cause, 32'h8000_0001);
    ack();
    wr(4'hC, 32'h0);

    // W1C withdraws a request before ack; stray ack ignored afterwards
    wr(4'h4, 32'hFF);
    irq_in[4] = 1'b1;
    cause_q.push_back(32'h8000_0004);
    tickn(LAT);
    chk("id4", int_cause, 32'h8000_0004);
    irq_in[4] = 1'b0;
    wr(4'h0, 32'h10);
    tick();
    chk("w1c_drop", {31'b0, int_signal}, 32'h0);
    rd(4'h8, 32'h0);
    ack();
    chk("stray_ack", {31'b0, int_signal}, 32'h0);
    rd(4'h0, 32'h0);
    irq_in[6] = 1'b1;
    cause_q.push_back(32'h8000_0006);
    tickn(LAT);
    chk("id6", int_cause, 32'h8000_0006);
    irq_in[6] = 1'b0;
    ack();

    // New edge during SERVICE waits for EOI
    irq_in[0] = 1'b1;
    tickn(LAT + 2);
    chk("svc_hold", {31'b0, int_signal}, 32'h0);
    irq_in[0] = 1'b0;
    rd(4'h8, 32'h8000_0006);
    cause_q.push_back(32'h8000_0000);
    wr(4'hC, 32'h0);
    chk("eoi_edge2", {31'b0, int_signal}, 32'h0);
    tick();
    chk("id0", int_cause, 32'h8000_0000);

    // Reset while requesting
    reset = 1'b0;
    tick();
    chk("mid_rst_int", {31'b0, int_signal}, 32'h0);
    chk("mid_rst_cause", int_cause, 32'h0);
    chk("mid_rst_ready", {31'b0, ready}, 32'h0);
    reset = 1'b1;
    rd(4'h0, 32'h0);
    rd(4'h4, 32'h0);
    rd(4'h8, 32'h0);

    tickn(3);
    chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
    chk("cause_q_drained", 32'(cause_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
